// File: rtl/ftch_imem_pkg.sv
// Fetch-stage <-> instruction-memory packet types, shared by the fetch stage and mem_arb.
package ftch_imem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } ftch_imem_pkt_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
    } imem_ftch_pkt_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Types shared by the unified-memory arbiter: data-side and RAM-side packets, FSM state, owner.
package mem_arb_pkg;

    localparam int BE_W = ftch_imem_pkg::DATA_W / 8;

    typedef struct packed {
        logic [ftch_imem_pkg::ADDR_W-1:0] addr;
        logic [ftch_imem_pkg::DATA_W-1:0] wdata;
        logic                             we;
        logic [BE_W-1:0]                  be;
    } mem_arb_pkt_t;

    typedef struct packed {
        logic [ftch_imem_pkg::DATA_W-1:0] rdata;
    } arb_mem_pkt_t;

    typedef struct packed {
        logic [ftch_imem_pkg::ADDR_W-1:0] addr;
        logic [ftch_imem_pkg::DATA_W-1:0] wdata;
        logic                             we;
        logic [BE_W-1:0]                  be;
    } arb_ram_pkt_t;

    typedef enum logic [1:0] {IDLE, REQ, RSP} arb_state_e;
    typedef enum logic [1:0] {NONE, FTCH, MEM} owner_e;

    // Instruction fetches are always full-word reads.
    function automatic arb_ram_pkt_t ftch_ram_pkt(input logic [ftch_imem_pkg::ADDR_W-1:0] addr);
        arb_ram_pkt_t p;
        p.addr  = addr;
        p.wdata = '0;
        p.we    = 1'b0;
        p.be    = '1;
        return p;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Fetch, data and RAM handshake bundle of mem_arb; slave = arbiter side, master = environment side.
interface mem_arb_if;
    import ftch_imem_pkg::*;
    import mem_arb_pkg::*;

    logic           ftch_imem_vld;
    ftch_imem_pkt_t ftch_imem_pkt;
    logic           ftch_imem_rdy;
    imem_ftch_pkt_t imem_ftch_pkt;
    logic           mem_arb_vld;
    mem_arb_pkt_t   mem_arb_pkt;
    logic           mem_arb_rdy;
    arb_mem_pkt_t   arb_mem_pkt;
    logic           arb_ram_vld;
    arb_ram_pkt_t   arb_ram_pkt;
    logic           ram_arb_rdy;
    logic           ram_arb_rsp_vld;
    logic [DATA_W-1:0] ram_arb_rsp_data;

    modport slave (
        input  ftch_imem_vld, ftch_imem_pkt, mem_arb_vld, mem_arb_pkt,
               ram_arb_rdy, ram_arb_rsp_vld, ram_arb_rsp_data,
        output ftch_imem_rdy, imem_ftch_pkt, mem_arb_rdy, arb_mem_pkt,
               arb_ram_vld, arb_ram_pkt
    );

    modport master (
        output ftch_imem_vld, ftch_imem_pkt, mem_arb_vld, mem_arb_pkt,
               ram_arb_rdy, ram_arb_rsp_vld, ram_arb_rsp_data,
        input  ftch_imem_rdy, imem_ftch_pkt, mem_arb_rdy, arb_mem_pkt,
               arb_ram_vld, arb_ram_pkt
    );

endinterface

// File: rtl/mem_arb_sel.sv
// Winner select for mem_arb. Default: mem priority with fetch starvation guard;
// MEM_ARB_RR_EN: alternate winners on contention using a last-owner bit.
module mem_arb_sel #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic arb_en,
    input  logic ftch_vld,
    input  logic mem_vld,
    output logic grant_ftch,
    output logic grant_mem
);

`ifdef MEM_ARB_RR_EN
    logic last_ftch;

    always_comb begin
        grant_ftch = 1'b0;
        grant_mem  = 1'b0;
        if (arb_en) begin
            if (ftch_vld && mem_vld) begin
                grant_mem  = last_ftch;
                grant_ftch = !last_ftch;
            end else begin
                grant_mem  = mem_vld;
                grant_ftch = ftch_vld;
            end
        end
    end

    // Reset to FTCH so the first tie goes to mem.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         last_ftch <= 1'b1;
        else if (grant_ftch) last_ftch <= 1'b1;
        else if (grant_mem)  last_ftch <= 1'b0;
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        grant_ftch = 1'b0;
        grant_mem  = 1'b0;
        if (arb_en) begin
            if (ftch_vld && mem_vld) begin
                grant_ftch = starved;
                grant_mem  = !starved;
            end else begin
                grant_mem  = mem_vld;
                grant_ftch = ftch_vld;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                  starve_cnt <= '0;
        else if (grant_ftch)                          starve_cnt <= '0;
        else if (grant_mem && ftch_vld && !starved)   starve_cnt <= starve_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: rtl/mem_arb.sv
// Single-outstanding arbiter sharing one RAM port between fetch and mem stages.
// Contention policy lives in mem_arb_sel (MEM_ARB_RR_EN selects round-robin).
//   state | meaning
//   IDLE  | arbitrate among requests valid this cycle, latch winner's packet
//   REQ   | present latched packet to RAM until ram_arb_rdy
//   RSP   | wait for ram_arb_rsp_vld, steer data to owner (fetch may be squashed)
module mem_arb import ftch_imem_pkg::*, mem_arb_pkg::*; #(
    parameter int STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      resetn,
    mem_arb_if.slave  bus
);

    arb_state_e   state, state_nxt;
    owner_e       owner, owner_nxt;
    arb_ram_pkt_t pkt_q, pkt_nxt;
    logic         grant_ftch, grant_mem;
    logic         rsp_now, mem_rsp, ftch_rsp;

    mem_arb_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
        .clk        (clk),
        .resetn     (resetn),
        .arb_en     (state == IDLE),
        .ftch_vld   (bus.ftch_imem_vld),
        .mem_vld    (bus.mem_arb_vld),
        .grant_ftch (grant_ftch),
        .grant_mem  (grant_mem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            owner <= NONE;
            pkt_q <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            pkt_q <= pkt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        pkt_nxt   = pkt_q;
        case (state)
            IDLE: begin
                if (grant_mem) begin
                    pkt_nxt   = bus.mem_arb_pkt;
                    owner_nxt = MEM;
                    state_nxt = REQ;
                end else if (grant_ftch) begin
                    pkt_nxt   = ftch_ram_pkt(bus.ftch_imem_pkt.addr);
                    owner_nxt = FTCH;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.ram_arb_rdy) state_nxt = RSP;
            end
            RSP: begin
                if (bus.ram_arb_rsp_vld) begin
                    owner_nxt = NONE;
                    state_nxt = IDLE;
                end
            end
            default: begin
                owner_nxt = NONE;
                state_nxt = IDLE;
            end
        endcase
    end

    // A fetch response only reaches the fetch stage if it still wants that address.
    assign rsp_now  = (state == RSP) && bus.ram_arb_rsp_vld;
    assign mem_rsp  = rsp_now && (owner == MEM);
    assign ftch_rsp = rsp_now && (owner == FTCH) && bus.ftch_imem_vld
                      && (bus.ftch_imem_pkt.addr == pkt_q.addr);

    assign bus.mem_arb_rdy   = mem_rsp;
    assign bus.arb_mem_pkt   = mem_rsp  ? arb_mem_pkt_t'(bus.ram_arb_rsp_data) : '0;
    assign bus.ftch_imem_rdy = ftch_rsp;
    assign bus.imem_ftch_pkt = ftch_rsp ? imem_ftch_pkt_t'(bus.ram_arb_rsp_data) : '0;
    assign bus.arb_ram_vld   = (state == REQ);
    assign bus.arb_ram_pkt   = pkt_q;

endmodule
